fcpu_io_bridge: RTL and testbench

AXI4 slave that terminates the fcpu IO port and converts it to the byte-stream valid/ready ports of serial_interface.
- Write channel: W beats become TX bytes. Each burst returns one B response.
- Read channel: R beats are served from an internal RX FIFO filled by the serial receiver.
- Sits between fcpu_inst (io_* ports) and serial_if_inst (i_*/o_* ports). It replaces the tied-off awready/arready/rlast constants at top level.

---
 rtl/fcpu_io_bridge.sv | 187 ++++++++++++++++++
 tb/tb_fcpu_io_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fcpu_io_bridge.sv
// rtl/fcpu_io_bridge.sv - AXI4 slave bridging fcpu io_* port to serial byte streams
// Optional status reads via araddr[2] when FCPU_IO_STATUS_EN is defined.
module fcpu_io_bridge #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int RX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ID_W-1:0]   io_awid,
  input  logic [ADDR_W-1:0] io_awaddr,
  input  logic [7:0]        io_awlen,
  input  logic              io_awvalid,
  output logic              io_awready,
  input  logic [7:0]        io_wdata,
  input  logic              io_wstrb,
  input  logic              io_wlast,
  input  logic              io_wvalid,
  output logic              io_wready,
  output logic [ID_W-1:0]   io_bid,
  output logic [1:0]        io_bresp,
  output logic              io_bvalid,
  input  logic              io_bready,
  input  logic [ID_W-1:0]   io_arid,
  input  logic [ADDR_W-1:0] io_araddr,
  input  logic [7:0]        io_arlen,
  input  logic              io_arvalid,
  output logic              io_arready,
  output logic [ID_W-1:0]   io_rid,
  output logic [7:0]        io_rdata,
  output logic [1:0]        io_rresp,
  output logic              io_rlast,
  output logic              io_rvalid,
  input  logic              io_rready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);
  localparam int PW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t        w_state_q, w_state_d;
  r_state_t        r_state_q, r_state_d;
  logic            en_q;
  logic [ID_W-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [7:0]      rlen_q, rlen_d, beat_q, beat_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]     count_q, count_d;
  logic [7:0]      mem [RX_DEPTH];
  logic            empty, full, push, pop, is_status;
  logic            unused_ok;

  assign unused_ok = ^{io_awaddr, io_awlen, io_araddr};

`ifdef FCPU_IO_STATUS_EN
  logic status_q, status_d;
  assign is_status = status_q;
`else
  assign is_status = 1'b0;
`endif

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (PW+1)'(RX_DEPTH));
    // en_q keeps every ready low until the first cycle after reset release
    rx_ready = en_q && !full;
    push     = rx_valid && rx_ready;

    io_awready = en_q && (w_state_q == W_IDLE);
    io_wready  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    if (w_state_q == W_DATA) begin
      if (io_wstrb) begin
        io_wready = tx_ready;
        tx_valid  = io_wvalid;
        tx_data   = io_wdata;
      end else begin
        io_wready = 1'b1;
      end
    end
    io_bvalid = (w_state_q == W_RESP);
    io_bid    = bid_q;
    io_bresp  = 2'b00;

    w_state_d = w_state_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: if (io_awvalid && io_awready) begin
        bid_d     = io_awid;
        w_state_d = W_DATA;
      end
      W_DATA: if (io_wvalid && io_wready && io_wlast) w_state_d = W_RESP;
      W_RESP: if (io_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase

    io_arready = en_q && (r_state_q == R_IDLE);
    io_rvalid  = 1'b0;
    io_rdata   = 8'h00;
    io_rlast   = 1'b0;
    io_rid     = rid_q;
    io_rresp   = 2'b00;
    if (r_state_q == R_DATA) begin
      io_rlast = (beat_q == rlen_q);
      if (is_status) begin
        io_rvalid = 1'b1;
        io_rdata  = {6'b0, tx_ready, !empty};
      end else begin
        io_rvalid = !empty;
        io_rdata  = empty ? 8'h00 : mem[rptr_q];
      end
    end
    pop = io_rvalid && io_rready && !is_status;

    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    beat_d    = beat_q;
`ifdef FCPU_IO_STATUS_EN
    status_d  = status_q;
`endif
    case (r_state_q)
      R_IDLE: if (io_arvalid && io_arready) begin
        rid_d     = io_arid;
        rlen_d    = io_arlen;
        beat_d    = 8'h00;
`ifdef FCPU_IO_STATUS_EN
        status_d  = io_araddr[2];
`endif
        r_state_d = R_DATA;
      end
      R_DATA: if (io_rvalid && io_rready) begin
        beat_d = beat_q + 8'd1;
        if (io_rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q      <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bid_q     <= '0;
      rid_q     <= '0;
      rlen_q    <= '0;
      beat_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
`ifdef FCPU_IO_STATUS_EN
      status_q  <= 1'b0;
`endif
    end else begin
      en_q      <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bid_q     <= bid_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      beat_q    <= beat_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
`ifdef FCPU_IO_STATUS_EN
      status_q  <= status_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= rx_data;
  end
endmodule

// File: tb/tb_fcpu_io_bridge.sv
// tb/tb_fcpu_io_bridge.sv - directed self-checking bench for fcpu_io_bridge
module tb_fcpu_io_bridge;
  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  io_awid, io_bid, io_arid, io_rid;
  logic [31:0] io_awaddr, io_araddr;
  logic [7:0]  io_awlen, io_arlen, io_wdata, io_rdata, tx_data, rx_data;
  logic        io_awvalid, io_awready, io_wstrb, io_wlast, io_wvalid, io_wready;
  logic [1:0]  io_bresp, io_rresp;
  logic        io_bvalid, io_bready, io_arvalid, io_arready;
  logic        io_rlast, io_rvalid, io_rready;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] txq[$];

  fcpu_io_bridge #(.ID_W(4), .ADDR_W(32), .RX_DEPTH(16)) dut (
    .clk(clk), .nrst(nrst),
    .io_awid(io_awid), .io_awaddr(io_awaddr), .io_awlen(io_awlen),
    .io_awvalid(io_awvalid), .io_awready(io_awready),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wlast(io_wlast),
    .io_wvalid(io_wvalid), .io_wready(io_wready),
    .io_bid(io_bid), .io_bresp(io_bresp), .io_bvalid(io_bvalid), .io_bready(io_bready),
    .io_arid(io_arid), .io_araddr(io_araddr), .io_arlen(io_arlen),
    .io_arvalid(io_arvalid), .io_arready(io_arready),
    .io_rid(io_rid), .io_rdata(io_rdata), .io_rresp(io_rresp), .io_rlast(io_rlast),
    .io_rvalid(io_rvalid), .io_rready(io_rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_valid && tx_ready) txq.push_back(tx_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, " awready"}, io_awready, 0);
    check({tag, " arready"}, io_arready, 0);
    check({tag, " wready"},  io_wready,  0);
    check({tag, " bvalid"},  io_bvalid,  0);
    check({tag, " rvalid"},  io_rvalid,  0);
    check({tag, " tx_valid"}, tx_valid,  0);
    check({tag, " rx_ready"}, rx_ready,  0);
  endtask

  initial begin
    nrst = 0;
    io_awid = 0; io_awaddr = 0; io_awlen = 0; io_awvalid = 0;
    io_wdata = 0; io_wstrb = 0; io_wlast = 0; io_wvalid = 0; io_bready = 0;
    io_arid = 0; io_araddr = 0; io_arlen = 0; io_arvalid = 0; io_rready = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    repeat (3) step();
    check_all_idle("reset");
    check("reset bid", io_bid, 0);
    check("reset rdata", io_rdata, 0);
    nrst = 1;
    step();
    check("post awready", io_awready, 1);
    check("post arready", io_arready, 1);
    check("post rx_ready", rx_ready, 1);

    // single-beat write
    io_awid = 3; io_awlen = 0; io_awvalid = 1;
    settle();
    check("t1 awready", io_awready, 1);
    step();
    io_awvalid = 0;
    io_wvalid = 1; io_wdata = 8'h41; io_wstrb = 1; io_wlast = 1; tx_ready = 1;
    settle();
    check("t1 tx_valid", tx_valid, 1);
    check("t1 tx_data", tx_data, 8'h41);
    check("t1 wready", io_wready, 1);
    check("t1 bvalid early", io_bvalid, 0);
    step();
    io_wvalid = 0; io_wlast = 0; io_bready = 1;
    settle();
    check("t1 bvalid", io_bvalid, 1);
    check("t1 bid", io_bid, 3);
    check("t1 bresp", io_bresp, 0);
    step();
    io_bready = 0;
    check("t1 bvalid clr", io_bvalid, 0);
    check("t1 awready back", io_awready, 1);
    check("t1 txq size", txq.size(), 1);

    // three-beat write with a null-strobe beat and tx back-pressure
    txq.delete();
    io_awid = 7; io_awlen = 2; io_awvalid = 1;
    step();
    io_awvalid = 0;
    io_wvalid = 1; io_wdata = 8'h10; io_wstrb = 1; io_wlast = 0; tx_ready = 1;
    settle();
    check("t2 b0 wready", io_wready, 1);
    step();
    io_wdata = 8'h11; io_wstrb = 0; tx_ready = 0;
    settle();
    check("t2 b1 wready", io_wready, 1);
    check("t2 b1 tx_valid", tx_valid, 0);
    step();
    io_wdata = 8'h12; io_wstrb = 1; io_wlast = 1;
    settle();
    check("t2 b2 wready stall", io_wready, 0);
    step();
    check("t2 bvalid stall", io_bvalid, 0);
    tx_ready = 1;
    settle();
    check("t2 b2 wready", io_wready, 1);
    step();
    io_wvalid = 0; io_wlast = 0;
    check("t2 bvalid", io_bvalid, 1);
    check("t2 bid", io_bid, 7);
    check("t2 txq size", txq.size(), 2);
    if (txq.size() == 2) begin
      check("t2 tx0", txq[0], 8'h10);
      check("t2 tx1", txq[1], 8'h12);
    end
    io_bready = 1;
    step();
    io_bready = 0;
    check("t2 bvalid clr", io_bvalid, 0);

    // two-byte read
    rx_valid = 1; rx_data = 8'h55;
    step();
    rx_data = 8'h66;
    step();
    rx_valid = 0;
    io_arid = 5; io_arlen = 1; io_arvalid = 1;
    step();
    io_arvalid = 0; io_rready = 1;
    settle();
    check("t3 rvalid0", io_rvalid, 1);
    check("t3 rdata0", io_rdata, 8'h55);
    check("t3 rlast0", io_rlast, 0);
    check("t3 rid", io_rid, 5);
    step();
    check("t3 rdata1", io_rdata, 8'h66);
    check("t3 rlast1", io_rlast, 1);
    step();
    check("t3 rvalid end", io_rvalid, 0);
    check("t3 arready", io_arready, 1);

    // read stalls on an empty FIFO
    io_arid = 2; io_arlen = 0; io_arvalid = 1;
    step();
    io_arvalid = 0;
    for (int i = 0; i < 20; i++) begin
      check("t4 stall rvalid", io_rvalid, 0);
      step();
    end
    rx_valid = 1; rx_data = 8'h7E;
    step();
    rx_valid = 0;
    check("t4 rvalid", io_rvalid, 1);
    check("t4 rdata", io_rdata, 8'h7E);
    check("t4 rlast", io_rlast, 1);
    step();
    check("t4 arready", io_arready, 1);
    io_rready = 0;

    // fill past depth, then drain with wrap
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1; rx_data = 8'hA0 + 8'(i);
      settle();
      check("t5 rx_ready fill", rx_ready, (i < 16) ? 1 : 0);
      step();
    end
    check("t5 rx_ready full", rx_ready, 0);
    io_arid = 1; io_arlen = 15; io_arvalid = 1;
    step();
    io_arvalid = 0; io_rready = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) check("t5 rx_ready reopen", rx_ready, 1);
      if (i == 2) rx_valid = 0;
      settle();
      check("t5 rdata", io_rdata, 8'hA0 + 8'(i));
      check("t5 rlast", io_rlast, (i == 15) ? 1 : 0);
      step();
    end
    io_arid = 4; io_arlen = 0; io_arvalid = 1;
    step();
    io_arvalid = 0;
    check("t5 wrap rvalid", io_rvalid, 1);
    check("t5 wrap rdata", io_rdata, 8'hB0);
    check("t5 wrap rlast", io_rlast, 1);
    step();
    check("t5 wrap empty", io_rvalid, 0);
    io_rready = 0;

    // reset in the middle of a write burst
    rx_valid = 1; rx_data = 8'h33;
    step();
    rx_valid = 0;
    io_awid = 9; io_awlen = 2; io_awvalid = 1;
    step();
    io_awvalid = 0;
    io_wvalid = 1; io_wdata = 8'h01; io_wstrb = 1; tx_ready = 1;
    step();
    io_wdata = 8'h02;
    nrst = 0;
    settle();
    check_all_idle("t6 in reset");
    io_wvalid = 0;
    step();
    nrst = 1;
    step();
    check("t6 awready", io_awready, 1);
    check("t6 bvalid", io_bvalid, 0);
`ifdef FCPU_IO_STATUS_EN
    io_araddr = 32'h4; io_arlen = 0; io_arvalid = 1;
    step();
    io_arvalid = 0; io_rready = 1;
    check("t6 status rvalid", io_rvalid, 1);
    check("t6 status rdata", io_rdata, 8'h02);
    step();
    io_araddr = 32'h0;
`endif
    io_arlen = 0; io_arvalid = 1; io_rready = 1;
    step();
    io_arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("t6 fifo empty", io_rvalid, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
